// File: rtl/leaf_stream_adapter.sv
// Buffered stream adapter between leaf_interface and an HLS kernel: one FWFT FIFO per channel.
// Define LEAF_ADAPTER_STATS_EN to build saturating per-channel pop counters on xfer_count.
module leaf_stream_adapter #(
  parameter int unsigned PAYLOAD_BITS  = 32,
  parameter int unsigned NUM_IN_PORTS  = 2,
  parameter int unsigned NUM_OUT_PORTS = 2,
  parameter int unsigned DEPTH_BITS    = 2
) (
  input  logic                                        clk_user,
  input  logic                                        reset,
  input  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]        dout_leaf_interface2user,
  input  logic [NUM_IN_PORTS-1:0]                     vld_interface2user,
  output logic [NUM_IN_PORTS-1:0]                     ack_user2interface,
  output logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]        kin_data,
  output logic [NUM_IN_PORTS-1:0]                     kin_vld,
  input  logic [NUM_IN_PORTS-1:0]                     kin_ack,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]       kout_data,
  input  logic [NUM_OUT_PORTS-1:0]                    kout_vld,
  output logic [NUM_OUT_PORTS-1:0]                    kout_ack,
  output logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]       din_leaf_user2interface,
  output logic [NUM_OUT_PORTS-1:0]                    vld_user2interface,
  input  logic [NUM_OUT_PORTS-1:0]                    ack_interface2user,
  output logic [NUM_IN_PORTS+NUM_OUT_PORTS-1:0]       chan_full,
  output logic [NUM_IN_PORTS+NUM_OUT_PORTS-1:0]       chan_empty,
  output logic [(NUM_IN_PORTS+NUM_OUT_PORTS)*16-1:0]  xfer_count
);

  localparam int unsigned NumChan = NUM_IN_PORTS + NUM_OUT_PORTS;
  localparam int unsigned Depth   = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] FullCount = {1'b1, {DEPTH_BITS{1'b0}}};

  for (genvar c = 0; c < NumChan; c++) begin : g_chan
    logic [PAYLOAD_BITS-1:0] wr_data;
    logic                    wr_vld;
    logic                    rd_ack;
    logic [PAYLOAD_BITS-1:0] mem_q [Depth];
    logic [DEPTH_BITS-1:0]   wr_ptr_q, rd_ptr_q;
    logic [DEPTH_BITS:0]     count_q, count_d;
    logic                    full_q, empty_q;
    logic                    push, pop;

    // Input channels occupy the low indices, output channels follow.
    if (c < NUM_IN_PORTS) begin : g_in
      assign wr_data                          = dout_leaf_interface2user[c*PAYLOAD_BITS +: PAYLOAD_BITS];
      assign wr_vld                           = vld_interface2user[c];
      assign rd_ack                           = kin_ack[c];
      assign ack_user2interface[c]            = ~full_q;
      assign kin_vld[c]                       = ~empty_q;
      assign kin_data[c*PAYLOAD_BITS +: PAYLOAD_BITS] = mem_q[rd_ptr_q];
    end else begin : g_out
      localparam int unsigned K = c - NUM_IN_PORTS;
      assign wr_data               = kout_data[K*PAYLOAD_BITS +: PAYLOAD_BITS];
      assign wr_vld                = kout_vld[K];
      assign rd_ack                = ack_interface2user[K];
      assign kout_ack[K]           = ~full_q;
      assign vld_user2interface[K] = ~empty_q;
      assign din_leaf_user2interface[K*PAYLOAD_BITS +: PAYLOAD_BITS] = mem_q[rd_ptr_q];
    end

    assign push = wr_vld & ~full_q;
    assign pop  = rd_ack & ~empty_q;

    always_comb begin
      count_d = count_q;
      if (push && !pop) begin
        count_d = count_q + 1'b1;
      end else if (pop && !push) begin
        count_d = count_q - 1'b1;
      end
    end

    always_ff @(posedge clk_user or posedge reset) begin
      if (reset) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
        full_q   <= 1'b0;
        empty_q  <= 1'b1;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        count_q <= count_d;
        full_q  <= (count_d == FullCount);
        empty_q <= (count_d == '0);
      end
    end

    // Storage is deliberately left unreset; only pointers define validity.
    always_ff @(posedge clk_user) begin
      if (push) mem_q[wr_ptr_q] <= wr_data;
    end

    assign chan_full[c]  = full_q;
    assign chan_empty[c] = empty_q;

`ifdef LEAF_ADAPTER_STATS_EN
    logic [15:0] cnt_q;
    always_ff @(posedge clk_user or posedge reset) begin
      if (reset) begin
        cnt_q <= '0;
      end else if (pop && (cnt_q != 16'hFFFF)) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
    assign xfer_count[c*16 +: 16] = cnt_q;
`else
    assign xfer_count[c*16 +: 16] = 16'h0;
`endif
  end

endmodule

// File: tb/tb_leaf_stream_adapter.sv
// Directed bench for leaf_stream_adapter at default parameters: vector table for channel 0
// plus hand sequences for wrap, independence, mid-stream reset and the optional counters.
module tb_leaf_stream_adapter;

  localparam int unsigned W    = 32;
  localparam int unsigned NIN  = 2;
  localparam int unsigned NOUT = 2;

  logic               clk_user = 1'b0;
  logic               reset;
  logic [NIN*W-1:0]   dout_leaf_interface2user;
  logic [NIN-1:0]     vld_interface2user;
  logic [NIN-1:0]     ack_user2interface;
  logic [NIN*W-1:0]   kin_data;
  logic [NIN-1:0]     kin_vld;
  logic [NIN-1:0]     kin_ack;
  logic [NOUT*W-1:0]  kout_data;
  logic [NOUT-1:0]    kout_vld;
  logic [NOUT-1:0]    kout_ack;
  logic [NOUT*W-1:0]  din_leaf_user2interface;
  logic [NOUT-1:0]    vld_user2interface;
  logic [NOUT-1:0]    ack_interface2user;
  logic [NIN+NOUT-1:0] chan_full;
  logic [NIN+NOUT-1:0] chan_empty;
  logic [(NIN+NOUT)*16-1:0] xfer_count;

  leaf_stream_adapter dut (
    .clk_user                (clk_user),
    .reset                   (reset),
    .dout_leaf_interface2user(dout_leaf_interface2user),
    .vld_interface2user      (vld_interface2user),
    .ack_user2interface      (ack_user2interface),
    .kin_data                (kin_data),
    .kin_vld                 (kin_vld),
    .kin_ack                 (kin_ack),
    .kout_data               (kout_data),
    .kout_vld                (kout_vld),
    .kout_ack                (kout_ack),
    .din_leaf_user2interface (din_leaf_user2interface),
    .vld_user2interface      (vld_user2interface),
    .ack_interface2user      (ack_interface2user),
    .chan_full               (chan_full),
    .chan_empty              (chan_empty),
    .xfer_count              (xfer_count)
  );

  always #5 clk_user = ~clk_user;

  typedef struct {
    logic        vld;
    logic [31:0] din;
    logic        kack;
    logic        e_vld;
    logic [31:0] e_data;
    logic        e_ack;
    logic        e_full;
    logic        e_empty;
  } vec_t;

  vec_t tbl[$];
  int   vectors = 0;
  int   fails   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic vld, input logic [31:0] din, input logic kack,
                     input logic e_vld, input logic [31:0] e_data, input logic e_ack,
                     input logic e_full, input logic e_empty);
    vec_t v;
    v.vld = vld; v.din = din; v.kack = kack;
    v.e_vld = e_vld; v.e_data = e_data; v.e_ack = e_ack;
    v.e_full = e_full; v.e_empty = e_empty;
    tbl.push_back(v);
  endtask

  task automatic idle_inputs();
    dout_leaf_interface2user = '0;
    vld_interface2user       = '0;
    kin_ack                  = '0;
    kout_data                = '0;
    kout_vld                 = '0;
    ack_interface2user       = '0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_kin_vld"},   64'(kin_vld), 64'h0);
    check({tag, "_ack_in"},    64'(ack_user2interface), 64'h3);
    check({tag, "_kout_ack"},  64'(kout_ack), 64'h3);
    check({tag, "_vld_out"},   64'(vld_user2interface), 64'h0);
    check({tag, "_empty"},     64'(chan_empty), 64'hF);
    check({tag, "_full"},      64'(chan_full), 64'h0);
    check({tag, "_xfer"},      xfer_count[63:0], 64'h0);
  endtask

  initial begin
    int sent, recv, bubbles, full_seen, sent0;
    logic [31:0] act_data;

    // Each record: expected state seen at a negedge, then the inputs for the next rising edge.
    // Pass-through, then fill to full with one refused word, drain, then push+pop at count 1.
    add(1, 32'hA5A5_0001, 1,  0, 32'h0,          1, 0, 1);
    add(0, 32'h0,         1,  1, 32'hA5A5_0001,  1, 0, 0);
    add(0, 32'h0,         0,  0, 32'h0,          1, 0, 1);
    add(1, 32'd1,         0,  0, 32'h0,          1, 0, 1);
    add(1, 32'd2,         0,  1, 32'd1,          1, 0, 0);
    add(1, 32'd3,         0,  1, 32'd1,          1, 0, 0);
    add(1, 32'd4,         0,  1, 32'd1,          1, 0, 0);
    add(1, 32'd5,         0,  1, 32'd1,          0, 1, 0);
    add(0, 32'h0,         1,  1, 32'd1,          0, 1, 0);
    add(0, 32'h0,         1,  1, 32'd2,          1, 0, 0);
    add(0, 32'h0,         1,  1, 32'd3,          1, 0, 0);
    add(0, 32'h0,         1,  1, 32'd4,          1, 0, 0);
    add(1, 32'h10,        0,  0, 32'h0,          1, 0, 1);
    add(1, 32'h11,        1,  1, 32'h10,         1, 0, 0);
    add(0, 32'h0,         1,  1, 32'h11,         1, 0, 0);
    add(0, 32'h0,         0,  0, 32'h0,          1, 0, 1);

    idle_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk_user);
    reset = 1'b0;
    @(negedge clk_user);
    check_reset_state("reset");

    for (int i = 0; i < tbl.size(); i++) begin
      act_data = tbl[i].e_vld ? kin_data[31:0] : 32'h0;
      check($sformatf("tbl%0d", i),
            {28'h0, kin_vld[0], ack_user2interface[0], chan_full[0], chan_empty[0], act_data},
            {28'h0, tbl[i].e_vld, tbl[i].e_ack, tbl[i].e_full, tbl[i].e_empty, tbl[i].e_data});
      vld_interface2user[0]            = tbl[i].vld;
      dout_leaf_interface2user[31:0]   = tbl[i].din;
      kin_ack[0]                       = tbl[i].kack;
      @(negedge clk_user);
    end
    idle_inputs();

`ifndef LEAF_ADAPTER_STATS_EN
    check("xfer_tied_zero", xfer_count[63:0], 64'h0);
`endif

    // Output channel 1: concurrent push/pop for 20 words across several pointer wraps.
    sent = 0; recv = 0; bubbles = 0; full_seen = 0;
    ack_interface2user[1] = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk_user);
      if (vld_user2interface[1]) begin
        check($sformatf("wrap_word%0d", recv), 64'(din_leaf_user2interface[63:32]),
              64'(32'hB000_0000 + recv));
        recv++;
      end else if (recv > 0 && recv < 20) begin
        bubbles++;
      end
      if (chan_full[3]) full_seen++;
      if (sent < 20 && kout_ack[1]) begin
        kout_vld[1]       = 1'b1;
        kout_data[63:32]  = 32'hB000_0000 + sent;
        sent++;
      end else begin
        kout_vld[1] = 1'b0;
      end
    end
    check("wrap_count", 64'(recv), 64'd20);
    check("wrap_bubbles", 64'(bubbles), 64'd0);
    check("wrap_full_seen", 64'(full_seen), 64'd0);
    idle_inputs();

    // Channel 0 stalled with 3 words buffered while channel 1 streams.
    sent = 0; recv = 0; bubbles = 0; sent0 = 0;
    kin_ack[1] = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk_user);
      if (kin_vld[1]) begin
        check($sformatf("indep_word%0d", recv), 64'(kin_data[63:32]), 64'(32'hC0 + recv));
        recv++;
      end else if (recv > 0 && recv < 8) begin
        bubbles++;
      end
      if (sent < 8 && ack_user2interface[1]) begin
        vld_interface2user[1]          = 1'b1;
        dout_leaf_interface2user[63:32] = 32'hC0 + sent;
        sent++;
      end else begin
        vld_interface2user[1] = 1'b0;
      end
      if (sent0 < 3 && ack_user2interface[0]) begin
        vld_interface2user[0]          = 1'b1;
        dout_leaf_interface2user[31:0] = 32'h100 + sent0;
        sent0++;
      end else begin
        vld_interface2user[0] = 1'b0;
      end
    end
    check("indep_count", 64'(recv), 64'd8);
    check("indep_bubbles", 64'(bubbles), 64'd0);
    check("stall_head", {31'h0, kin_vld[0], kin_data[31:0]}, {31'h0, 1'b1, 32'h100});
    check("stall_not_full", 64'(chan_full[0]), 64'h0);
    idle_inputs();

    // Asynchronous reset between edges must empty everything at once.
    #1 reset = 1'b1;
    #1 check_reset_state("midreset");
    @(negedge clk_user);
    reset = 1'b0;
    @(negedge clk_user);
    check_reset_state("post_reset");

`ifdef LEAF_ADAPTER_STATS_EN
    begin
      int pops;
      pops = 0;
      vld_interface2user[0] = 1'b1;
      dout_leaf_interface2user[31:0] = 32'h5A;
      kin_ack[0] = 1'b1;
      for (int cyc = 0; cyc < 70005; cyc++) begin
        @(negedge clk_user);
        if (cyc == 100) check("stats_early", 64'(xfer_count[15:0]), 64'(pops));
        if (kin_vld[0]) pops++;
      end
      idle_inputs();
      @(negedge clk_user);
      check("stats_pops_model", 64'(pops > 70000), 64'd1);
      check("stats_saturated", 64'(xfer_count[15:0]), 64'hFFFF);
      check("stats_other_chan", 64'(xfer_count[31:16]), 64'h0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/leaf_stream_adapter.md
# leaf_stream_adapter

Parametrised, buffered stream adapter between `leaf_interface` and an HLS user kernel inside a leaf. It generalises the fixed two-in/two-out direct wiring to any number of input and output channels. Every channel gets a first-word-fall-through FIFO, so the kernel and the interface are decoupled. Per-channel occupancy flags are provided, and optional transfer counters can be compiled in.

## Interface
Parameters:
- `PAYLOAD_BITS`, 32, data width per channel
- `NUM_IN_PORTS`, 2, interface→kernel channels (1..16)
- `NUM_OUT_PORTS`, 2, kernel→interface channels (1..16)
- `DEPTH_BITS`, 2, FIFO depth = 2^DEPTH_BITS per channel (1..7)

Ports (channel k occupies bits [k*W +: W]; W is the per-channel width):
- `clk_user` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-high
- `dout_leaf_interface2user` in NUM_IN_PORTS*PAYLOAD_BITS: data from interface
- `vld_interface2user` in NUM_IN_PORTS: interface data valid
- `ack_user2interface` out NUM_IN_PORTS: adapter accepts
- `kin_data` out NUM_IN_PORTS*PAYLOAD_BITS: data to kernel `Input_k_V_V`
- `kin_vld` out NUM_IN_PORTS: to kernel `_ap_vld`
- `kin_ack` in NUM_IN_PORTS: from kernel `_ap_ack`
- `kout_data` in NUM_OUT_PORTS*PAYLOAD_BITS: from kernel `Output_k_V_V`
- `kout_vld` in NUM_OUT_PORTS: from kernel `_ap_vld`
- `kout_ack` out NUM_OUT_PORTS: to kernel `_ap_ack`
- `din_leaf_user2interface` out NUM_OUT_PORTS*PAYLOAD_BITS: data to interface
- `vld_user2interface` out NUM_OUT_PORTS: valid to interface
- `ack_interface2user` in NUM_OUT_PORTS: interface accepts
- `chan_full` out NUM_IN_PORTS+NUM_OUT_PORTS: FIFO full flags, input channels in the low bits
- `chan_empty` out NUM_IN_PORTS+NUM_OUT_PORTS: FIFO empty flags, same ordering
- `xfer_count` out (NUM_IN_PORTS+NUM_OUT_PORTS)*16: per-channel pop counters, same ordering

## Operation
- Each channel has one identical FIFO instance:
  - Write side: data/vld/ack.
  - Read side: data/vld/ack.
  - A transfer occurs on any cycle where vld=1 and ack=1 at the clock edge.
- Write ack is `!full`, a registered flag. Ack does not depend combinationally on vld.
- Read vld is `!empty`, a registered flag. Read data is the head entry and is stable while vld=1 and ack=0.
- State per FIFO:
  - `wr_ptr` and `rd_ptr` are DEPTH_BITS wide and wrap modulo 2^DEPTH_BITS.
  - `count` is DEPTH_BITS+1 wide, range 0..2^DEPTH_BITS.
  - push: count+1; pop: count−1; push and pop together: count unchanged, both pointers advance.
- Full = (count == 2^DEPTH_BITS). Empty = (count == 0). Both flags are registered from the next-state count.
- No bypass: a word pushed into an empty FIFO is not visible on the read side in the same cycle.
- Channels are fully independent. A stall on one channel never blocks another.
- Reset:
  - Pointers, counts and counters go to 0. Memory contents are not reset.
  - Reset values: all `ack_user2interface`, `kout_ack` = 1 (FIFOs empty, not full). All `kin_vld`, `vld_user2interface` = 0. `chan_empty` = all 1. `chan_full` = all 0. `xfer_count` = 0.
  - Data outputs are don't-care while the matching vld=0.
  - Asserting reset mid-stream discards buffered words immediately, asynchronously.

## Timing
- Latency: a word pushed at edge t raises read-side vld after edge t (visible in cycle t+1). Minimum latency is 1 cycle.
- Throughput: 1 word/cycle/channel sustained when both sides are ready.
- Full, pop only: the same edge clears full, and ack=1 in the next cycle.
- Full, write vld=1: no push, because ack=0.
- Empty, push only: vld=1 from the next cycle.
- Count = 1, simultaneous push and pop: FIFO stays non-empty. The new word is at the head in the next cycle.
- Pointer wrap from 2^DEPTH_BITS−1 to 0 is seamless, with no bubble.

## Configuration
- `LEAF_ADAPTER_STATS_EN`:
  - Defined: each channel has a 16-bit counter that increments on every read-side transfer. It saturates at 16'hFFFF and clears only on reset.
  - Undefined: no counter logic is built, and `xfer_count` is tied to 0.

## Test plan
- Reset, then idle: after `reset` deassertion, `kin_vld`=0, `ack_user2interface`=2'b11, `chan_empty`=4'hF, `xfer_count`=0.
- Pass-through: push 0xA5A5_0001 on input channel 0 with kernel ack=1 → `kin_data[31:0]`=0xA5A5_0001 and `kin_vld[0]`=1 exactly one cycle later, then `kin_vld[0]`=0.
- Fill/full: DEPTH_BITS=2, kernel ack=0, push 5 words 1..5 → only 1..4 accepted, `ack_user2interface[0]`=0 and `chan_full[0]`=1 after the 4th push. Releasing ack pops 1,2,3,4 in order.
- Wrap and concurrency: push/pop every cycle for 20 words on output channel 1 → in-order 20 words, `chan_full` never 1, no bubbles.
- Independence and mid-run reset: stall channel 0, stream channel 1 → channel 1 unaffected. Assert `reset` with 3 words buffered → empty immediately and outputs return to reset values.
- Stats (macro defined): 70000 pops on channel 0 → `xfer_count[15:0]`=16'hFFFF. Without the macro the field reads 0.
